// File: rtl/div_54_20_seq.sv
// Sequential radix-2 restoring divider: signed 54-bit dividend by a sign/magnitude
// 20-bit divisor, producing a saturated 31-bit two's-complement quotient and remainder magnitude.
module div_54_20_seq #(
    parameter int unsigned DW = 54,
    parameter int unsigned BW = 20,
    parameter int unsigned QW = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] signed_C,
    input  logic [BW-1:0] B,
    input  logic          sign_B,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] Q,
    output logic [BW-1:0] R,
    output logic          ovf,
    output logic          dbz
);

    localparam int unsigned CW = $clog2(DW);
    localparam logic [DW-1:0] QPOS_LIM = {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
    localparam logic [DW-1:0] QNEG_LIM = QPOS_LIM + DW'(1);
    localparam logic [QW-1:0] QMAX     = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN     = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;     // dividend bits shift out the top, quotient bits in at the bottom
    logic [BW-1:0] rem_q, rem_d;
    logic [BW-1:0] b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [QW-1:0] q_q, q_d;
    logic [BW-1:0] r_q, r_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;

    logic [DW-1:0] mag_c;
    logic [BW:0]   shifted_c;
    logic [BW:0]   diff_c;
    logic          ge_c;

    assign mag_c     = signed_C[DW-1] ? (DW'(0) - signed_C) : signed_C;
    assign shifted_c = {rem_q, acc_q[DW-1]};
    assign diff_c    = shifted_c - {1'b0, b_q};
    assign ge_c      = (shifted_c >= {1'b0, b_q});

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = mag_c;
                    b_d     = B;
                    neg_d   = signed_C[DW-1] ^ sign_B;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Remainder stays below B, so the truncated difference/restore fits BW bits
                acc_d = {acc_q[DW-2:0], ge_c};
                rem_d = BW'(ge_c ? diff_c : shifted_c);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW-1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (b_q == '0) begin
                    dbz_d = 1'b1;
                    ovf_d = 1'b0;
                    r_d   = '0;
                    q_d   = neg_q ? QMIN : QMAX;
                end else begin
                    dbz_d = 1'b0;
                    r_d   = rem_q;
                    if (!neg_q && (acc_q > QPOS_LIM)) begin
                        q_d   = QMAX;
                        ovf_d = 1'b1;
                    end else if (neg_q && (acc_q > QNEG_LIM)) begin
                        q_d   = QMIN;
                        ovf_d = 1'b1;
                    end else begin
                        q_d   = neg_q ? (QW'(0) - acc_q[QW-1:0]) : acc_q[QW-1:0];
                        ovf_d = 1'b0;
                    end
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign ovf  = ovf_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_54_20_seq.sv
// Bench for div_54_20_seq: vector table through a scoreboard, plus control-path sequences.
module tb_div_54_20_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [53:0] signed_C;
    logic [19:0] B;
    logic        sign_B;
    logic        busy;
    logic        done;
    logic [30:0] Q;
    logic [19:0] R;
    logic        ovf;
    logic        dbz;

    div_54_20_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .signed_C (signed_C),
        .B        (B),
        .sign_B   (sign_B),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .ovf      (ovf),
        .dbz      (dbz)
    );

    typedef struct {
        logic [53:0] c;
        logic [19:0] b;
        logic        sb;
        logic [30:0] q;
        logic [19:0] r;
        logic        ovf;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [30:0] q;
        logic [19:0] r;
        logic        ovf;
        logic        dbz;
        int          cyc0;
        int          id;
    } exp_t;

    localparam int NV = 16;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vt[NV];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want, input int id);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s id=%0d got=%0h want=%0h", nm, id, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [53:0] c, input logic [19:0] b, input logic sb,
                                input logic [30:0] q, input logic [19:0] r,
                                input logic ov, input logic dz);
        vec_t v;
        v.c = c; v.b = b; v.sb = sb; v.q = q; v.r = r; v.ovf = ov; v.dbz = dz;
        return v;
    endfunction

    // Result monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0, -1);
            end else begin
                mon_e = sb_q.pop_front();
                check("Q",       64'(Q),   64'(mon_e.q),   mon_e.id);
                check("R",       64'(R),   64'(mon_e.r),   mon_e.id);
                check("ovf",     64'(ovf), 64'(mon_e.ovf), mon_e.id);
                check("dbz",     64'(dbz), 64'(mon_e.dbz), mon_e.id);
                check("latency", 64'(cyc - mon_e.cyc0), 64'd56, mon_e.id);
                check("busy_at_done", 64'(busy), 64'd0, mon_e.id);
            end
        end
    end

    task automatic start_op(input vec_t v, input int id);
        exp_t e;
        signed_C = v.c;
        B        = v.b;
        sign_B   = v.sb;
        start    = 1'b1;
        e.q = v.q; e.r = v.r; e.ovf = v.ovf; e.dbz = v.dbz; e.cyc0 = cyc; e.id = id;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_on", 64'(busy), 64'd1, id);
    endtask

    task automatic wait_done(input int id);
        int lows;
        bit seen;
        lows = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) lows++;
                @(negedge clk);
            end
        end
        check("done_seen", 64'(seen), 64'd1, id);
        check("busy_hold", 64'(lows), 64'd0, id);
    endtask

    initial begin
        vt[0]  = mk(54'd1000,                 20'd7,   1'b0, 31'd142,        20'd6,    1'b0, 1'b0);
        vt[1]  = mk(54'd0 - 54'd1000,         20'd7,   1'b0, 31'h7FFFFF72,   20'd6,    1'b0, 1'b0);
        vt[2]  = mk(54'd0 - 54'd1000,         20'd7,   1'b1, 31'd142,        20'd6,    1'b0, 1'b0);
        vt[3]  = mk(54'd0 - 54'd8369910,      20'd678, 1'b0, 31'h7FFFCFC7,   20'd0,    1'b0, 1'b0);
        vt[4]  = mk(54'd8369910,              20'd678, 1'b1, 31'h7FFFCFC7,   20'd0,    1'b0, 1'b0);
        vt[5]  = mk(54'd1 << 40,              20'd1,   1'b1, 31'h40000000,   20'd0,    1'b1, 1'b0);
        vt[6]  = mk(54'd1 << 40,              20'd1,   1'b0, 31'h3FFFFFFF,   20'd0,    1'b1, 1'b0);
        vt[7]  = mk(54'd0 - (54'd1 << 30),    20'd1,   1'b0, 31'h40000000,   20'd0,    1'b0, 1'b0);
        vt[8]  = mk(54'd5,                    20'd0,   1'b0, 31'h3FFFFFFF,   20'd0,    1'b0, 1'b1);
        vt[9]  = mk(54'd0 - 54'd5,            20'd0,   1'b0, 31'h40000000,   20'd0,    1'b0, 1'b1);
        vt[10] = mk(54'd0,                    20'd5,   1'b1, 31'd0,          20'd0,    1'b0, 1'b0);
        vt[11] = mk(54'd0 - 54'd3,            20'd7,   1'b0, 31'd0,          20'd3,    1'b0, 1'b0);
        vt[12] = mk((54'd1 << 30) - 54'd1,    20'd1,   1'b0, 31'h3FFFFFFF,   20'd0,    1'b0, 1'b0);
        vt[13] = mk(54'd1 << 30,              20'd1,   1'b0, 31'h3FFFFFFF,   20'd0,    1'b1, 1'b0);
        vt[14] = mk({1'b1, 53'd0},            20'hFFFFF, 1'b0, 31'h40000000, 20'd8192, 1'b1, 1'b0);
        vt[15] = mk(54'd123456789,            20'd1000, 1'b0, 31'd123456,    20'd789,  1'b0, 1'b0);

        rst      = 1'b1;
        start    = 1'b0;
        signed_C = '0;
        B        = '0;
        sign_B   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0, -1);
        check("rst_done", 64'(done), 64'd0, -1);
        check("rst_Q",    64'(Q),    64'd0, -1);
        check("rst_R",    64'(R),    64'd0, -1);
        check("rst_ovf",  64'(ovf),  64'd0, -1);
        check("rst_dbz",  64'(dbz),  64'd0, -1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            start_op(vt[i], i);
            wait_done(i);
            @(negedge clk);
        end

        // Start while busy is ignored; inputs may change mid-operation
        start_op(vt[0], 100);
        repeat (9) @(negedge clk);
        signed_C = 54'd999999;
        B        = 20'd3;
        sign_B   = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        repeat (70) @(negedge clk);

        // Reset mid-operation aborts with no done
        start_op(vt[1], 200);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0, 200);
        check("abort_done", 64'(done), 64'd0, 200);
        check("abort_Q",    64'(Q),    64'd0, 200);
        check("abort_R",    64'(R),    64'd0, 200);
        rst = 1'b0;
        repeat (70) @(negedge clk);

        start_op(vt[3], 201);
        wait_done(201);
        @(negedge clk);

        // Back-to-back: start during the done cycle
        start_op(vt[15], 300);
        wait_done(300);
        start_op(vt[2], 301);
        wait_done(301);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
